// File: rtl/instructions_pkg.sv
// Shared constants and small types for the RV32 front end.
package instructions_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Where the decode-side output register takes its next word from.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_FIFO   = 2'd1,
    SRC_BYPASS = 2'd2
  } load_src_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO with flush; flush beats push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: credit-limited imem requests, in-order responses,
// prefetch FIFO with a same-cycle bypass into the decode output register.
module fetch_stage
  import instructions_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter int unsigned     MAX_OUTST  = 2
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic [XLEN-1:0] Instruction,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_pls4,
  output logic            instr_valid
);

  localparam int unsigned     OCW  = $clog2(MAX_OUTST + 1);
  localparam int unsigned     FCW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned     SW   = FCW + 1;
  localparam logic [XLEN-1:0] NOP  = XLEN'(NOP_INSTR);
  localparam logic [XLEN-1:0] STEP = XLEN'(4);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] opc;
  logic [OCW-1:0]  outst_cnt;
  logic [OCW-1:0]  drop_cnt;
  logic [FCW-1:0]  fifo_cnt;
  logic [SW-1:0]   credit_used;
  logic            fifo_full;
  logic            fifo_empty;
  logic [XLEN-1:0] fifo_head;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fire;
  logic            keep;
  logic            load;
  logic [XLEN-1:0] redirect_base;
  load_src_e       src_p0;
  logic [XLEN-1:0] word_p0;

  // Request side: every in-flight request must have a FIFO slot reserved.
  assign credit_used   = SW'(outst_cnt) + SW'(fifo_cnt);
  assign imem_req      = !redirect_valid
                         && (credit_used < SW'(FIFO_DEPTH))
                         && (outst_cnt < OCW'(MAX_OUTST));
  assign imem_addr     = fpc;
  assign fire          = imem_req && imem_gnt;
  assign redirect_base = word_align(redirect_pc);

  // Response side: stale words are dropped, the rest bypass or queue.
  assign keep = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
  assign load = !stall || !instr_valid;

  always_comb begin
    src_p0 = SRC_NONE;
    if (load && !redirect_valid) begin
      if (!fifo_empty) src_p0 = SRC_FIFO;
      else if (keep)   src_p0 = SRC_BYPASS;
    end
  end

  always_comb begin
    word_p0 = fifo_head;
    if (src_p0 == SRC_BYPASS) word_p0 = imem_rdata;
  end

  assign fifo_pop  = (src_p0 == SRC_FIFO);
  assign fifo_push = keep && (src_p0 != SRC_BYPASS);

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .din   (imem_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt),
    .head  (fifo_head)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fpc       <= RESET_PC;
      outst_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      outst_cnt <= outst_cnt + OCW'(fire) - OCW'(imem_rvalid);
      if (redirect_valid) begin
        fpc      <= redirect_base;
        drop_cnt <= outst_cnt - OCW'(imem_rvalid);
      end else begin
        if (fire) fpc <= fpc + STEP;
        if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OCW'(1);
      end
    end
  end

  // Decode-facing output register; opc tracks the pc of the next word loaded.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      instr_valid <= 1'b0;
      Instruction <= NOP;
      pc          <= RESET_PC;
      pc_pls4     <= RESET_PC + STEP;
      opc         <= RESET_PC;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
      Instruction <= NOP;
      opc         <= redirect_base;
    end else if (load) begin
      if (src_p0 != SRC_NONE) begin
        instr_valid <= 1'b1;
        Instruction <= word_p0;
        pc          <= opc;
        pc_pls4     <= opc + STEP;
        opc         <= opc + STEP;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

  a_rvalid_needs_outstanding : assert property (
    @(posedge clk) disable iff (!rstn) imem_rvalid |-> (outst_cnt != '0));

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!rstn) (fifo_push && !redirect_valid) |-> (!fifo_full || fifo_pop));

  a_addr_aligned : assert property (
    @(posedge clk) disable iff (!rstn) imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: in-order memory model plus an expected
// pc stream that restarts at every reset or redirect target.
module tb_fetch_stage;
  import instructions_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam int unsigned FD   = 2;
  localparam int unsigned MO   = 2;
  localparam logic [31:0] KEY  = 32'hA5A5_0000;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] Instruction;
  logic [31:0] pc;
  logic [31:0] pc_pls4;
  logic        instr_valid;

  fetch_stage #(
    .XLEN       (XLEN),
    .RESET_PC   (RPC),
    .FIFO_DEPTH (FD),
    .MAX_OUTST  (MO)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .Instruction    (Instruction),
    .pc             (pc),
    .pc_pls4        (pc_pls4),
    .instr_valid    (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } rsp_t;

  rsp_t        pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  int unsigned cyc      = 0;

  int unsigned lat, gnt_pct, rv_pct, stall_pct, gnt_hold;
  logic [31:0] hold_addr, redir_target;
  logic        redir_req;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (gnt_hold > 0 && imem_addr == hold_addr) begin
      imem_gnt = 1'b0;
      gnt_hold--;
    end else begin
      imem_gnt = ($urandom_range(99) < gnt_pct);
    end
    stall          = ($urandom_range(99) < stall_pct);
    redirect_valid = redir_req;
    redirect_pc    = redir_target;
    redir_req      = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].addr ^ KEY;
      void'(pend.pop_front());
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    cyc++;
    rstn = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    stall = 1'b0;
    redir_req = 1'b0;
    pend.delete();
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rstn = 1'b1;
  endtask

  // Monitor: pops the expected stream on every newly presented instruction.
  logic        prev_vld, prev_stall, prev_redir, prev_req, prev_gnt;
  logic [31:0] prev_pc, prev_instr, prev_addr, e;

  always @(negedge clk) begin
    if (!rstn) begin
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instruction", Instruction, NOP_INSTR);
      check("rst_pc", pc, RPC);
      check("rst_pc_pls4", pc_pls4, RPC + 32'd4);
      check("rst_imem_addr", imem_addr, RPC);
      exp_q.delete();
      exp_next   = RPC;
      prev_vld   = 1'b0;
      prev_stall = 1'b0;
      prev_redir = 1'b0;
      prev_req   = 1'b0;
      prev_gnt   = 1'b0;
    end else begin
      while (exp_q.size() < 8) begin
        exp_q.push_back(exp_next);
        exp_next = exp_next + 32'd4;
      end
      if (prev_redir) begin
        check("redirect_clears_valid", 32'(instr_valid), 32'd0);
        check("redirect_nop", Instruction, NOP_INSTR);
      end
      if (prev_vld && prev_stall && !prev_redir) begin
        check("stall_hold_valid", 32'(instr_valid), 32'd1);
        check("stall_hold_pc", pc, prev_pc);
        check("stall_hold_instr", Instruction, prev_instr);
      end else if (instr_valid) begin
        e = exp_q.pop_front();
        check("out_pc", pc, e);
        check("out_instr", Instruction, e ^ KEY);
        check("out_pc_pls4", pc_pls4, e + 32'd4);
        n_out++;
      end
      if (redirect_valid) check("req_low_on_redirect", 32'(imem_req), 32'd0);
      if (prev_req && !prev_gnt && !prev_redir && !redirect_valid) begin
        check("req_held_until_gnt", 32'(imem_req), 32'd1);
        check("addr_held_until_gnt", imem_addr, prev_addr);
      end
      if (imem_req) check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
      if (imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + lat});
      check("outstanding_limit", 32'(pend.size() <= MO), 32'd1);
      if (redirect_valid) begin
        exp_q.delete();
        exp_next = {redirect_pc[31:2], 2'b00};
      end
      prev_vld   = instr_valid;
      prev_stall = stall;
      prev_redir = redirect_valid;
      prev_req   = imem_req;
      prev_gnt   = imem_gnt;
      prev_pc    = pc;
      prev_instr = Instruction;
      prev_addr  = imem_addr;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  int grants, seen, withheld, got, out_before;

  initial begin
    rstn = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    lat = 1; gnt_pct = 100; rv_pct = 100; stall_pct = 0; gnt_hold = 0;
    hold_addr = '0; redir_target = '0; redir_req = 1'b0;
    #1 rstn = 1'b0;
    do_reset(2);

    // Streaming start-up, then a 5-cycle stall at pc=8.
    step(); #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RPC);
    step(); #1;
    check("c1_not_valid", 32'(instr_valid), 32'd0);
    step(); #1;
    check("c2_valid", 32'(instr_valid), 32'd1);
    check("c2_pc", pc, RPC);
    step(); #1;
    check("c3_pc", pc, RPC + 32'd4);
    stall_pct = 100;
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      check("stall_pc_frozen", pc, RPC + 32'd8);
      if (imem_req && imem_gnt) grants++;
    end
    check("stall_req_dropped", 32'(imem_req), 32'd0);
    check("stall_grants_le2", 32'(grants <= 2), 32'd1);
    stall_pct = 0;
    step(); #1; check("release_pc8", pc, RPC + 32'd8);
    step(); #1; check("release_pc12", pc, RPC + 32'd12);
    step(); #1; check("release_pc16", pc, RPC + 32'd16);
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      check("stream_no_gap", 32'(instr_valid), 32'd1);
    end

    // gnt withheld for 3 cycles at 0x10.
    do_reset(2);
    hold_addr = 32'h10; gnt_hold = 3; seen = 0; withheld = 0;
    for (int i = 0; i < 20; i++) begin
      step(); #1;
      if (imem_addr == 32'h10) begin
        seen++;
        if (!imem_gnt) withheld++;
        check("hold_req_high", 32'(imem_req), 32'd1);
      end
    end
    check("hold_withheld_cycles", 32'(withheld), 32'd3);
    check("hold_addr_cycles", 32'(seen), 32'd4);

    // Redirect to 0x100 with two requests in flight, 3-cycle latency.
    do_reset(2);
    lat = 3; got = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pend.size() == 2) begin
        got = 1;
        break;
      end
    end
    check("redir_two_outstanding", 32'(got), 32'd1);
    redir_req = 1'b1; redir_target = 32'h100; got = 0;
    for (int i = 0; i < 30; i++) begin
      step(); #1;
      if (instr_valid) begin
        got = 1;
        break;
      end
    end
    check("redir_valid_seen", 32'(got), 32'd1);
    check("redir_pc", pc, 32'h100);
    check("redir_pc_pls4", pc_pls4, 32'h104);
    check("redir_instr", Instruction, 32'h100 ^ KEY);

    // Redirect coincident with stall and a returning word.
    do_reset(2);
    lat = 1;
    repeat (6) step();
    stall_pct = 100; redir_req = 1'b1; redir_target = 32'h203;
    step(); #1;
    check("coinc_rvalid_present", 32'(imem_rvalid), 32'd1);
    stall_pct = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      step(); #1;
      if (instr_valid) begin
        got = 1;
        break;
      end
    end
    check("coinc_valid_seen", 32'(got), 32'd1);
    check("coinc_pc", pc, 32'h200);
    check("coinc_instr", Instruction, 32'h200 ^ KEY);

    // Asynchronous reset with the FIFO full.
    do_reset(2);
    lat = 1;
    repeat (4) step();
    stall_pct = 100;
    repeat (4) step();
    #1;
    check("full_req_blocked", 32'(imem_req), 32'd0);
    rstn = 1'b0;
    #1;
    check("async_rst_valid", 32'(instr_valid), 32'd0);
    check("async_rst_instr", Instruction, NOP_INSTR);
    check("async_rst_pc", pc, RPC);
    check("async_rst_pc_pls4", pc_pls4, RPC + 32'd4);
    pend.delete();
    stall_pct = 0;
    do_reset(1);
    step(); #1;
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", imem_addr, RPC);
    repeat (4) step();

    // Randomized traffic.
    out_before = n_out;
    gnt_pct = 70; rv_pct = 80; stall_pct = 30;
    for (int seg = 0; seg < 12; seg++) begin
      lat = $urandom_range(4, 1);
      if (seg % 4 == 3) do_reset(1 + int'($urandom_range(1)));
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(99) < 3) begin
          redir_req = 1'b1;
          redir_target = $urandom;
        end
        step();
      end
    end
    stall_pct = 0;
    repeat (10) step();
    check("random_outputs_seen", 32'(n_out - out_before > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
